// File: rtl/accum_nco_pkg.sv
// rtl/accum_nco_pkg.sv - shared constants and helpers for the accum_nco phase accumulator
package accum_nco_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  localparam int OVF_CNT_W = 8;

  // Channel index width; a single channel still gets a 1-bit select port.
  function automatic int ch_w(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/accum_nco_lane.sv
// rtl/accum_nco_lane.sv - one NCO channel: step register, accumulator, wrap pulse (ACCUM_NCO_OVF_CNT_EN adds an overflow counter)
module accum_nco_lane
  import accum_nco_pkg::*;
#(
  parameter int W    = 11,
  parameter int MODE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_step_we,
  input  logic [W-1:0] i_step_data,
  output logic [W-1:0] o_acc,
  output logic         o_msb,
  output logic         o_wrap
`ifdef ACCUM_NCO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] o_ovf_cnt
`endif
);

  logic [W-1:0] r_step;
  logic [W-1:0] r_acc;
  logic         r_wrap;
  logic [W:0]   w_sum;
  logic [W-1:0] w_acc_next;

  // Carry out of the W+1 bit sum is the overflow indication in both modes.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_step};

  // Next accumulator value: modulo wrap, or clamp to all-ones when saturating.
  always_comb begin
    w_acc_next = w_sum[W-1:0];
    if ((MODE == MODE_SAT) && w_sum[W]) begin
      w_acc_next = '1;
    end
  end

  // Step register and accumulator; a step write only affects the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (i_step_we) begin
        r_step <= i_step_data;
      end
      if (i_clr) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
      end else if (i_en) begin
        r_acc  <= w_acc_next;
        r_wrap <= w_sum[W];
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

`ifdef ACCUM_NCO_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Saturating count of wrap events, bumped on the edge that raises the pulse.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ovf_cnt <= '0;
    end else if (i_en && w_sum[W] && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

  assign o_acc  = r_acc;
  assign o_msb  = r_acc[W-1];
  assign o_wrap = r_wrap;

endmodule

// File: rtl/accum_nco.sv
// rtl/accum_nco.sv - multi-channel phase accumulator top (ACCUM_NCO_OVF_CNT_EN adds ovf_cnt output)
module accum_nco
  import accum_nco_pkg::*;
#(
  parameter int W    = 11,
  parameter int CH   = 4,
  parameter int MODE = MODE_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  step_we,
  input  logic [ch_w(CH)-1:0]   step_ch,
  input  logic [W-1:0]          step_data,
  output logic [CH*W-1:0]       acc_out,
  output logic [CH-1:0]         msb_out,
  output logic [CH-1:0]         wrap_pulse
`ifdef ACCUM_NCO_OVF_CNT_EN
  ,
  output logic [CH*OVF_CNT_W-1:0] ovf_cnt
`endif
);

  logic [CH-1:0] w_lane_we;

  // One lane per channel; an out-of-range step_ch matches no lane and is dropped.
  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign w_lane_we[k] = step_we && (int'(step_ch) == k);

    accum_nco_lane #(
      .W    (W),
      .MODE (MODE)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_en        (en),
      .i_clr       (clr),
      .i_step_we   (w_lane_we[k]),
      .i_step_data (step_data),
      .o_acc       (acc_out[k*W +: W]),
      .o_msb       (msb_out[k]),
      .o_wrap      (wrap_pulse[k])
`ifdef ACCUM_NCO_OVF_CNT_EN
      ,
      .o_ovf_cnt   (ovf_cnt[k*OVF_CNT_W +: OVF_CNT_W])
`endif
    );
  end

endmodule
